seg_number_formatter: RTL and testbench
=======================================

Name: seg_number_formatter

Overview:
- Sequential binary-to-display formatter that sits directly upstream of the 8-digit segment scanner.
- Accepts an unsigned binary value on a start handshake.
- Converts the value to 8 BCD digits by iterative shift-add-3 (double-dabble), one bit per clock.
- Encodes the digits into eight active-low segment patterns o0..o7 (o0 = leftmost/most significant) and holds them until the next conversion.

Parameters:
- WIDTH, 27, bit width of the input value; legal range 1..27, since 8 decimal digits need at most 27 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  conversion request pulse; accepted only when busy=0
- value  in  WIDTH  unsigned binary value; sampled on the accepting edge
- blank_lz  in  1  1 = blank leading zeros; sampled on the accepting edge
- dp  in  8  decimal-point mask, active-high; dp[7] maps to o0 … dp[0] maps to o7; sampled on the accepting edge
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; o0..o7 become valid in the same cycle
- ovf  out  1  last accepted value exceeded 99_999_999
- o0..o7  out  8 each  segment patterns; bit7 = dp, bit6 = g … bit0 = a; active-low; 8'hFF = blank

Behaviour:
- Reset, evaluated at every edge and taking priority over everything:
  - state returns to IDLE
  - busy=0, done=0, ovf=0
  - o0..o7 = 8'hFF
  - an in-flight conversion is abandoned and produces no done pulse.
- FSM states:
  - IDLE: start=1 at edge E0 → latch value, blank_lz and dp; clear the 32-bit BCD accumulator; load bit counter = WIDTH; go to SHIFT; busy=1.
  - SHIFT: each edge E1..E_WIDTH, first add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. The counter decrements; at 0 go to ENCODE.
  - ENCODE: edge E_(WIDTH+1) registers o0..o7 and ovf, sets done=1 and busy=0, returns to IDLE.
- Latency: done is high in the cycle following edge WIDTH+1 after the accepting edge. For the default WIDTH this is 28 clocks.
- done is high for exactly one cycle.
- start while busy=1 is ignored and not queued. start in the same cycle done is high is accepted, because state is IDLE.
- o0..o7 hold their previous values throughout a conversion, so the display does not flicker.
- Digit encoding, before the dp bit is applied:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF, minus=BF
- dp application: the final pattern has bit7 cleared when the corresponding dp bit is 1, including on blanked digits, so a blanked digit with dp set shows 7F.
- Leading-zero blanking (blank_lz=1): digits left of the most significant nonzero digit show blank. o7 is never blanked, so value 0 shows a single 0.
- Overflow: a latched value > 99_999_999 (possible only when WIDTH=27) runs the same latency and timing. Result is ovf=1 and all outputs = BF, with dp and blank_lz ignored. ovf stays valid until the next done.
- Width rules: value is zero-extended to 27 bits internally; the BCD accumulator is 32 bits (8 nibbles). Nibble 7 maps to o0.

Decomposition:
- Shared package: seg pattern constants (SEG_DIGIT[0..9], SEG_BLANK=8'hFF, SEG_MINUS=8'hBF, SEG_DP_BIT=7), MAX_DEC=99_999_999, and FSM state encoding (IDLE, SHIFT, ENCODE).
- One natural combinational sub-module: seg_digit_encoder (4-bit BCD plus blank flag plus dp bit → 8-bit pattern), instantiated 8 times.

Test Plan:
- Reset → with rst held 2 cycles, all o=FF, busy=0, done=0, ovf=0. start asserted during rst is ignored.
- value=12_345_678, blank_lz=0, dp=0 → done exactly 28 clocks after the accepting edge; o0..o7 = F9,A4,B0,99,92,82,F8,80; ovf=0.
- value=305, blank_lz=1 → o0..o4=FF, o5=B0, o6=C0, o7=92. Repeat with blank_lz=0 → o0..o4=C0.
- value=0, blank_lz=1, dp=8'b0000_0100 → o0..o4=FF, o5=7F, o6=FF, o7=C0.
- value=100_000_000 → ovf=1, all o=BF. Then value=7 → ovf=0, o7=F8.
- start pulse at cycle 5 of a conversion is ignored, so only one done results. rst asserted at cycle 10 of a conversion → next cycle busy=0, all o=FF, and no done within 40 cycles.

Source files
------------

// File: rtl/seg_number_formatter_pkg.sv
// Shared constants for the segment number formatter: active-low segment
// patterns, the decimal limit of eight digits and the FSM state encoding.
package seg_number_formatter_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  // Patterns are active-low, bit0 = a ... bit6 = g, bit7 = dp.
  localparam logic [9:0][7:0] SEG_DIGIT = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [7:0]  SEG_MINUS  = 8'hBF;
  localparam int          SEG_DP_BIT = 7;
  localparam logic [31:0] MAX_DEC    = 32'd99_999_999;

  function automatic logic [7:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_DIGIT[0];
      4'd1:    return SEG_DIGIT[1];
      4'd2:    return SEG_DIGIT[2];
      4'd3:    return SEG_DIGIT[3];
      4'd4:    return SEG_DIGIT[4];
      4'd5:    return SEG_DIGIT[5];
      4'd6:    return SEG_DIGIT[6];
      4'd7:    return SEG_DIGIT[7];
      4'd8:    return SEG_DIGIT[8];
      4'd9:    return SEG_DIGIT[9];
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_number_formatter_digit_encoder.sv
// One BCD digit to an active-low segment pattern; the decimal point is applied
// after blanking so a blanked position can still show its dot.
module seg_digit_encoder
  import seg_number_formatter_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg_of_digit(bcd);
    if (dp) seg[SEG_DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/seg_number_formatter.sv
// Iterative binary-to-BCD (double-dabble, one bit per clock) feeding eight
// segment encoders; the display registers only change when a conversion ends.
module seg_number_formatter
  import seg_number_formatter_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             blank_lz,
  input  logic [7:0]       dp,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [7:0]       o0,
  output logic [7:0]       o1,
  output logic [7:0]       o2,
  output logic [7:0]       o3,
  output logic [7:0]       o4,
  output logic [7:0]       o5,
  output logic [7:0]       o6,
  output logic [7:0]       o7
);

  state_t             state;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   bin_p1;
  logic [31:0]        bcd_p1;
  logic [7:0]         dp_p0;
  logic               blank_p0;
  logic               ovf_p0;
  logic [7:0]         blank_dig;
  logic               lead_zero;
  logic [7:0]         pat  [8];
  logic [7:0]         disp [8];

  function automatic logic [31:0] dabble_adj(input logic [31:0] b);
    logic [31:0] r;
    for (int n = 0; n < 8; n++) begin
      r[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
    end
    return r;
  endfunction

  // Stage p0: capture request attributes on the accepting edge
  // Stage p1: shift-add-3 datapath, one input bit per clock
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      bin_p1   <= value;
      bcd_p1   <= '0;
      dp_p0    <= dp;
      blank_p0 <= blank_lz;
      ovf_p0   <= (32'(value) > MAX_DEC);
    end else if (state == SHIFT) begin
      {bcd_p1, bin_p1} <= {dabble_adj(bcd_p1), bin_p1} << 1;
    end
  end

  // Digit index 0 is the leftmost display position (BCD nibble 7).
  always_comb begin
    lead_zero = blank_p0;
    blank_dig = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_p1[(7-i)*4 +: 4] != 4'd0) lead_zero = 1'b0;
      blank_dig[i] = lead_zero && (i != 7);
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_enc
    seg_digit_encoder u_enc (
      .bcd   (bcd_p1[(7-g)*4 +: 4]),
      .blank (blank_dig[g]),
      .dp    (dp_p0[7-g]),
      .seg   (pat[g])
    );
  end

  // Stage p2: control FSM and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      for (int i = 0; i < 8; i++) disp[i] <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= 5'(WIDTH);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= ENCODE;
        end
        ENCODE: begin
          for (int i = 0; i < 8; i++) disp[i] <= ovf_p0 ? SEG_MINUS : pat[i];
          ovf   <= ovf_p0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o0 = disp[0];
  assign o1 = disp[1];
  assign o2 = disp[2];
  assign o3 = disp[3];
  assign o4 = disp[4];
  assign o5 = disp[5];
  assign o6 = disp[6];
  assign o7 = disp[7];

endmodule

// File: tb/tb_seg_number_formatter.sv
// Randomized and directed bench for seg_number_formatter against a decimal
// arithmetic reference model.
module tb_seg_number_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [26:0] value = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  dp = '0;
  logic        busy, done, ovf;
  logic [7:0]  o0, o1, o2, o3, o4, o5, o6, o7;
  logic [63:0] outs;

  int errors = 0;
  int checks = 0;

  logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_number_formatter #(.WIDTH(27)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .blank_lz(blank_lz), .dp(dp), .busy(busy), .done(done), .ovf(ovf),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7)
  );

  always #5 clk = ~clk;
  assign outs = {o0, o1, o2, o3, o4, o5, o6, o7};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input int unsigned v, input bit blz, input logic [7:0] dpm);
    logic [63:0] res;
    logic [7:0]  p;
    int unsigned div;
    int unsigned d;
    bit          lead;
    if (v > 99_999_999) return {8{8'hBF}};
    div  = 10_000_000;
    lead = blz;
    res  = '0;
    for (int i = 0; i < 8; i++) begin
      d = (v / div) % 10;
      div = div / 10;
      if (d != 0) lead = 0;
      p = (lead && i != 7) ? 8'hFF : lut[d];
      if (dpm[7-i]) p[7] = 1'b0;
      res[63-8*i -: 8] = p;
    end
    return res;
  endfunction

  // Starts in the cycle after a sampling point, returns at the sampling point where done is seen.
  task automatic run_conv(input int unsigned v, input bit blz, input logic [7:0] dpm, input string tag);
    logic [63:0] prev;
    int lat;
    prev = outs;
    lat  = 0;
    start = 1'b1; value = v[26:0]; blank_lz = blz; dp = dpm;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
      else if (k == 10) check({tag, "_hold"}, outs, prev);
    end
    check({tag, "_latency"}, lat, 28);
    check({tag, "_ovf"}, ovf, (v > 99_999_999) ? 1 : 0);
    check({tag, "_segs"}, outs, model(v, blz, dpm));
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int dones;
    int unsigned rv;

    // reset held two cycles with start asserted
    start = 1'b1; value = 27'd42;
    repeat (2) @(posedge clk);
    #1;
    check("rst_segs", outs, {8{8'hFF}});
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_ignored", busy, 0);

    run_conv(12_345_678, 0, 8'h00, "dec8");
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    run_conv(305, 1, 8'h00, "blz305");
    run_conv(305, 0, 8'h00, "nblz305");
    run_conv(0, 1, 8'b0000_0100, "zero_dp");
    run_conv(100_000_000, 1, 8'hFF, "ovf");
    run_conv(7, 0, 8'h00, "after_ovf");
    run_conv(99_999_999, 1, 8'h81, "max");

    // start during conversion ignored
    @(posedge clk); #1;
    start = 1'b1; value = 27'd4321; blank_lz = 1'b1; dp = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin start = 1'b1; value = 27'd8888; end
      if (k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_segs", outs, model(4321, 1, 8'h00));

    // reset mid-conversion abandons it
    start = 1'b1; value = 27'd55_555; blank_lz = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_segs", outs, {8{8'hFF}});
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    // randomized, back-to-back (start in the cycle done is high)
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(3, 0))
        0:       rv = $urandom_range(999, 0);
        1:       rv = $urandom_range(99_999_999, 0);
        2:       rv = $urandom_range(134_217_727, 99_999_990);
        default: rv = $urandom_range(134_217_727, 0);
      endcase
      run_conv(rv, 1'($urandom_range(1, 0)), 8'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
